localbus_master: RTL and testbench

- Host-side initiator for the UM localbus. It is the requester that drives the configuration port of the UM localbus slave, which writes parser/lookup rule sets and reads back results.
- Converts a simple valid/ready command interface (single read or write) into the localbus ALE/CS/ACK handshake.
- Returns read data and per-transaction error status.
- Used by the bench and by the on-board control path to program rule sets.

---
 rtl/localbus_master.sv | 147 ++++++++++++++
 tb/tb_localbus_master.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/localbus_master.sv
// UM localbus initiator: turns single read/write commands into the
// ALE/CS/ACK handshake and reports data, error status and counters.
module localbus_master #(
    parameter int          TIMEOUT  = 256,
    parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_rd,
    input  logic [31:0] cmd_addr,
    input  logic [31:0] cmd_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        localbus_cs_n,
    output logic        localbus_rd_wr,
    output logic [31:0] localbus_data,
    output logic        localbus_ale,
    input  logic        localbus_ack_n,
    input  logic [31:0] localbus_data_out,
    output logic [15:0] txn_count,
    output logic [7:0]  err_count
);

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        DATA,
        REL,
        WAITHI
    } state_t;

    state_t      state;
    state_t      state_n;
    logic [15:0] cnt;
    logic [15:0] cnt_n;
    logic        rd_q;
    logic [31:0] wdata_q;
    logic        accept;
    logic        to_rel;
    logic        timed_out;
    logic        cnt_last;
    logic [31:0] data_n;

    assign cnt_last = (cnt == 16'(TIMEOUT - 1));
    assign accept   = (state == IDLE) && cmd_valid && cmd_ready;

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        to_rel    = 1'b0;
        timed_out = 1'b0;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    state_n = ADDR;
                    cnt_n   = '0;
                end
            end
            ADDR: state_n = DATA;
            DATA: begin
                if (!localbus_ack_n) begin
                    state_n = REL;
                    to_rel  = 1'b1;
                end else if (cnt_last) begin
                    state_n   = REL;
                    to_rel    = 1'b1;
                    timed_out = 1'b1;
                end else begin
                    cnt_n = cnt + 16'd1;
                end
            end
            REL: begin
                state_n = WAITHI;
                cnt_n   = '0;
            end
            WAITHI: begin
                // a slave stuck on ack must not hang the host forever
                if (localbus_ack_n || cnt_last) begin
                    state_n = IDLE;
                end else begin
                    cnt_n = cnt + 16'd1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with it.
    always_comb begin
        data_n = '0;
        if (state_n == ADDR) begin
            data_n = cmd_addr;
        end else if (state_n == DATA && !rd_q) begin
            data_n = wdata_q;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= IDLE;
            cnt            <= '0;
            rd_q           <= 1'b1;
            wdata_q        <= '0;
            cmd_ready      <= 1'b0;
            rsp_valid      <= 1'b0;
            rsp_rdata      <= '0;
            rsp_err        <= 1'b0;
            localbus_cs_n  <= 1'b1;
            localbus_ale   <= 1'b0;
            localbus_rd_wr <= 1'b1;
            localbus_data  <= '0;
            txn_count      <= '0;
            err_count      <= '0;
        end else begin
            state          <= state_n;
            cnt            <= cnt_n;
            cmd_ready      <= (state_n == IDLE);
            localbus_ale   <= (state_n == ADDR);
            localbus_cs_n  <= (state_n != DATA);
            localbus_rd_wr <= (state_n == DATA) ? rd_q : 1'b1;
            localbus_data  <= data_n;
            rsp_valid      <= to_rel;
            rsp_err        <= timed_out;
            if (accept) begin
                rd_q    <= cmd_rd;
                wdata_q <= cmd_wdata;
            end
            if (to_rel) begin
                if (!rd_q) begin
                    rsp_rdata <= '0;
                end else if (timed_out) begin
                    rsp_rdata <= ERR_DATA;
                end else begin
                    rsp_rdata <= localbus_data_out;
                end
                txn_count <= txn_count + 16'd1;
                if (timed_out && err_count != 8'hFF) begin
                    err_count <= err_count + 8'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_localbus_master.sv
// Directed bench for localbus_master: write, read, timeout, stuck ack,
// back-to-back writes and reset in the middle of a transaction.
module tb_localbus_master;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_rd;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        cs_n;
    logic        rd_wr;
    logic [31:0] lb_data;
    logic        ale;
    logic        ack_n;
    logic [31:0] data_out;
    logic [15:0] txn_count;
    logic [7:0]  err_count;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    localbus_master #(
        .TIMEOUT (TO),
        .ERR_DATA(32'hDEAD_BEEF)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .cmd_valid        (cmd_valid),
        .cmd_ready        (cmd_ready),
        .cmd_rd           (cmd_rd),
        .cmd_addr         (cmd_addr),
        .cmd_wdata        (cmd_wdata),
        .rsp_valid        (rsp_valid),
        .rsp_rdata        (rsp_rdata),
        .rsp_err          (rsp_err),
        .localbus_cs_n    (cs_n),
        .localbus_rd_wr   (rd_wr),
        .localbus_data    (lb_data),
        .localbus_ale     (ale),
        .localbus_ack_n   (ack_n),
        .localbus_data_out(data_out),
        .txn_count        (txn_count),
        .err_count        (err_count)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        int   lowcnt;
        int   extra;
        int   rdycnt;
        int   acc;
        int   nrsp;
        int   rsp_at[3];
        logic will_acc;

        reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_rd    = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        ack_n     = 1'b1;
        data_out  = '0;
        #1 reset  = 1'b0;

        // reset state
        step();
        step();
        chk1("rst_cs_n", cs_n, 1'b1);
        chk1("rst_ale", ale, 1'b0);
        chk1("rst_rd_wr", rd_wr, 1'b1);
        chk32("rst_data", lb_data, 32'h0);
        chk1("rst_ready", cmd_ready, 1'b0);
        chk1("rst_rsp_valid", rsp_valid, 1'b0);
        chk32("rst_rdata", rsp_rdata, 32'h0);
        chk1("rst_rsp_err", rsp_err, 1'b0);
        chk32("rst_txn", 32'(txn_count), 32'h0);
        chk32("rst_errc", 32'(err_count), 32'h0);
        @(negedge clk);
        reset = 1'b1;
        step();
        chk1("rel_ready", cmd_ready, 1'b1);

        // write, ack three cycles into CS
        cmd_valid = 1'b1;
        cmd_rd    = 1'b0;
        cmd_addr  = 32'h0000_0010;
        cmd_wdata = 32'h1234_5678;
        step();
        chk1("wr_ale", ale, 1'b1);
        chk1("wr_ale_cs_n", cs_n, 1'b1);
        chk32("wr_ale_data", lb_data, 32'h10);
        chk1("wr_ale_ready", cmd_ready, 1'b0);
        cmd_valid = 1'b0;
        step();
        chk1("wr_cs_n", cs_n, 1'b0);
        chk1("wr_cs_ale", ale, 1'b0);
        chk1("wr_rd_wr", rd_wr, 1'b0);
        chk32("wr_cs_data", lb_data, 32'h1234_5678);
        step();
        chk1("wr_wait1_cs_n", cs_n, 1'b0);
        step();
        chk1("wr_wait2_cs_n", cs_n, 1'b0);
        chk1("wr_wait2_rsp", rsp_valid, 1'b0);
        ack_n = 1'b0;
        step();
        chk1("wr_rsp_valid", rsp_valid, 1'b1);
        chk1("wr_rsp_err", rsp_err, 1'b0);
        chk32("wr_rsp_rdata", rsp_rdata, 32'h0);
        chk1("wr_rel_cs_n", cs_n, 1'b1);
        chk32("wr_rel_data", lb_data, 32'h0);
        chk32("wr_txn", 32'(txn_count), 32'h1);
        ack_n = 1'b1;
        step();
        chk1("wr_waithi_rsp", rsp_valid, 1'b0);
        chk1("wr_waithi_ready", cmd_ready, 1'b0);
        step();
        chk1("wr_idle_ready", cmd_ready, 1'b1);

        // read
        cmd_valid = 1'b1;
        cmd_rd    = 1'b1;
        cmd_addr  = 32'h0000_0020;
        cmd_wdata = 32'hFFFF_FFFF;
        step();
        chk1("rd_ale", ale, 1'b1);
        chk32("rd_ale_data", lb_data, 32'h20);
        cmd_valid = 1'b0;
        step();
        chk1("rd_cs_n", cs_n, 1'b0);
        chk1("rd_rd_wr", rd_wr, 1'b1);
        chk32("rd_cs_data", lb_data, 32'h0);
        ack_n    = 1'b0;
        data_out = 32'hCAFE_0001;
        step();
        chk1("rd_rsp_valid", rsp_valid, 1'b1);
        chk32("rd_rsp_rdata", rsp_rdata, 32'hCAFE_0001);
        chk1("rd_rsp_err", rsp_err, 1'b0);
        chk32("rd_txn", 32'(txn_count), 32'h2);
        ack_n    = 1'b1;
        data_out = '0;
        step();
        step();
        chk1("rd_idle_ready", cmd_ready, 1'b1);

        // read that is never acknowledged
        cmd_valid = 1'b1;
        cmd_rd    = 1'b1;
        cmd_addr  = 32'h0000_0030;
        step();
        cmd_valid = 1'b0;
        lowcnt    = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (cs_n == 1'b0) lowcnt++;
            if (rsp_valid) break;
        end
        chk32("to_cs_low_cycles", 32'(lowcnt), 32'(TO));
        chk1("to_rsp_valid", rsp_valid, 1'b1);
        chk1("to_rsp_err", rsp_err, 1'b1);
        chk32("to_rsp_rdata", rsp_rdata, 32'hDEAD_BEEF);
        chk32("to_errc", 32'(err_count), 32'h1);
        chk32("to_txn", 32'(txn_count), 32'h3);
        step();
        step();
        chk1("to_idle_ready", cmd_ready, 1'b1);

        // slave keeps ack low after CS is released
        cmd_valid = 1'b1;
        cmd_rd    = 1'b0;
        cmd_addr  = 32'h0000_0040;
        cmd_wdata = 32'h0000_0055;
        step();
        cmd_valid = 1'b0;
        step();
        ack_n = 1'b0;
        step();
        chk1("stk_rsp_valid", rsp_valid, 1'b1);
        chk32("stk_txn", 32'(txn_count), 32'h4);
        extra  = 0;
        rdycnt = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (rsp_valid) extra++;
            if (cmd_ready) break;
            rdycnt++;
        end
        chk32("stk_busy_cycles", 32'(rdycnt), 32'(TO));
        chk1("stk_ready", cmd_ready, 1'b1);
        chk32("stk_extra_rsp", 32'(extra), 32'h0);
        chk32("stk_txn_after", 32'(txn_count), 32'h4);
        chk32("stk_errc_after", 32'(err_count), 32'h1);
        ack_n = 1'b1;
        step();

        // three back-to-back writes with an immediate-ack slave
        cmd_valid = 1'b1;
        cmd_rd    = 1'b0;
        cmd_addr  = 32'h0000_0100;
        cmd_wdata = 32'h0000_0001;
        acc       = 0;
        nrsp      = 0;
        rsp_at    = '{0, 0, 0};
        for (int cyc = 0; cyc < 40; cyc++) begin
            if (rsp_valid) begin
                if (nrsp < 3) rsp_at[nrsp] = cyc;
                nrsp++;
                chk1("b2b_rsp_err", rsp_err, 1'b0);
            end
            if (acc == 3 && nrsp == 3 && cmd_ready) break;
            ack_n    = cs_n;
            will_acc = cmd_ready && cmd_valid;
            step();
            if (will_acc) begin
                acc++;
                if (acc == 3) cmd_valid = 1'b0;
                else cmd_wdata = cmd_wdata + 32'd1;
            end
        end
        ack_n = 1'b1;
        chk32("b2b_nrsp", 32'(nrsp), 32'h3);
        chk32("b2b_gap1", 32'(rsp_at[1] - rsp_at[0]), 32'h5);
        chk32("b2b_gap2", 32'(rsp_at[2] - rsp_at[1]), 32'h5);
        chk32("b2b_txn", 32'(txn_count), 32'h7);

        // reset while CS is low
        cmd_valid = 1'b1;
        cmd_rd    = 1'b0;
        cmd_addr  = 32'h0000_0050;
        cmd_wdata = 32'h0BAD_0BAD;
        step();
        cmd_valid = 1'b0;
        step();
        chk1("mid_cs_low", cs_n, 1'b0);
        #2 reset = 1'b0;
        #1;
        chk1("mid_cs_n", cs_n, 1'b1);
        chk1("mid_ale", ale, 1'b0);
        chk32("mid_data", lb_data, 32'h0);
        chk1("mid_ready", cmd_ready, 1'b0);
        chk1("mid_rsp_valid", rsp_valid, 1'b0);
        chk32("mid_txn", 32'(txn_count), 32'h0);
        chk32("mid_errc", 32'(err_count), 32'h0);
        step();
        chk1("mid_hold_rsp", rsp_valid, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        step();
        chk1("post_ready", cmd_ready, 1'b1);
        chk1("post_rsp_valid", rsp_valid, 1'b0);
        cmd_valid = 1'b1;
        cmd_rd    = 1'b0;
        cmd_addr  = 32'h0000_0060;
        cmd_wdata = 32'hA5A5_A5A5;
        step();
        chk1("post_ale", ale, 1'b1);
        chk32("post_ale_data", lb_data, 32'h60);
        cmd_valid = 1'b0;
        step();
        chk1("post_cs_n", cs_n, 1'b0);
        chk32("post_cs_data", lb_data, 32'hA5A5_A5A5);
        ack_n = 1'b0;
        step();
        chk1("post_rsp_valid2", rsp_valid, 1'b1);
        chk1("post_rsp_err", rsp_err, 1'b0);
        chk32("post_txn", 32'(txn_count), 32'h1);
        ack_n = 1'b1;
        step();
        step();
        chk1("post_idle_ready", cmd_ready, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
